arith_seq_unit: RTL and testbench
=================================

# arith_seq_unit

Parametrised, registered successor to the 4-function combinational arithmetic core. Takes operand pairs through a valid/ready handshake and executes one of eight operations. Multiply runs as an iterative shift-add over WIDTH cycles. Presents result, upper product half and status flags until the consumer accepts them. Sits between a register-file/operand source and a result sink in the FPGA datapath exercises.

## Interface

Parameters:

- WIDTH, 8, operand/result width; power of two, 4..32.

Ports:

- i_clk  in  1  rising-edge clock
- i_rstn  in  1  reset; asynchronous, active-low
- i_valid  in  1  operand pair and opcode present
- o_ready  out  1  unit can accept (high only in IDLE)
- i_d_a  in  WIDTH  operand A
- i_d_b  in  WIDTH  operand B
- i_sel  in  3  opcode
- o_valid  out  1  result held on outputs
- i_ready  in  1  consumer accepts result
- o_out  out  WIDTH  result (low half for MUL)
- o_hi  out  WIDTH  MUL upper half; 0 otherwise
- o_carry  out  1  carry/borrow
- o_ovf  out  1  overflow
- o_zero  out  1  result zero
- o_err  out  1  opcode not implemented in this build

## Operation

- Opcodes: 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR, 5 MUL (unsigned), 6 SHL, 7 SHR (logical).
- SHL and SHR shift by i_d_b[$clog2(WIDTH)-1:0]. Upper bits of B are ignored.
- Accept: i_valid && o_ready at a rising edge. Capture A, B and sel.
- States:
  - IDLE: accept; non-MUL ops go to DONE; MUL goes to MUL.
  - MUL: WIDTH shift-add iterations, then DONE.
  - DONE: hold outputs; on i_ready go to IDLE.
- Flags:
  - ADD: carry = carry-out; ovf = signed overflow.
  - SUB: carry = borrow (A<B unsigned); ovf = signed overflow.
  - MUL: carry = 0; ovf = (o_hi != 0).
  - Logic and shift ops: carry = 0, ovf = 0.
- zero = (o_out == 0) for non-MUL ops, and ({o_hi,o_out} == 0) for MUL.
- i_valid while not IDLE is ignored; no queueing.
- Outputs are registered and stable throughout DONE.

## Timing

- Reset (any time, including mid-MUL): state IDLE; o_valid, o_out, o_hi, o_carry, o_ovf, o_zero, o_err = 0; o_ready = 1. The iteration counter clears.
- Non-MUL latency: o_valid high in the cycle after the accepting edge.
- MUL latency: o_valid high WIDTH cycles after the accepting edge.
- Result handshake: completes at an edge with o_valid && i_ready. o_valid drops and o_ready rises in the next cycle.
- Minimum issue interval: 2 cycles for non-MUL ops, WIDTH+1 cycles for MUL.
- i_ready held high in DONE: a single handshake, then IDLE.
- i_ready held low: outputs hold indefinitely.

## Configuration

- ARITH_SEQ_MUL_EN defined: opcode 5 is the iterative multiplier; o_err is always 0.
- ARITH_SEQ_MUL_EN undefined:
  - The MUL state and multiplier logic are removed.
  - Opcode 5 completes in 1 cycle with o_out = 0, o_hi = 0, zero = 1, carry = 0, ovf = 0 and o_err = 1.
  - All other opcodes are unchanged.

## Structure

- Package arith_seq_pkg holds:
  - opcode localparams OP_ADD..OP_SHR;
  - state encodings ST_IDLE, ST_MUL, ST_DONE;
  - flag bit positions.
- Sub-module arith_seq_mul is the iterative shift-add multiplier. It takes start, A and B, and returns done plus the 2·WIDTH product. It is instantiated only under ARITH_SEQ_MUL_EN.

## Test plan (WIDTH=8)

- ADD 100+97, i_ready=1 → o_out=0xC5, carry=0, ovf=1, zero=0; o_valid exactly 1 cycle after accept.
- SUB 2−1 → 0x01, carry=0. SUB 1−2 → 0xFF, carry=1, ovf=0.
- MUL 15×15 → o_out=0xE1, o_hi=0x00, ovf=0. MUL 100×97 → o_hi=0x25, o_out=0xE4, ovf=1. o_valid 8 cycles after accept.
- XOR 15^15 → 0x00, zero=1. SHL 0x81 by 1 → 0x02. SHR 0x80 by 7 → 0x01.
- Backpressure: hold i_ready=0 for 5 cycles in DONE while pulsing i_valid → outputs stable, o_ready=0, no new accept. The next op is correct.
- Reset at MUL cycle 3 → all outputs 0 and o_ready=1 immediately. A following ADD 2+1 → 0x03. Without the macro, MUL → o_err=1, o_out=0.

Source files
------------

// File: rtl/arith_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arith_seq_pkg
// Purpose  : Opcodes, FSM state encodings and flag bit positions shared by
//            the sequential arithmetic unit and its multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package arith_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int c_flag_carry = 0;
    localparam int c_flag_ovf   = 1;
    localparam int c_flag_zero  = 2;
    localparam int c_flag_err   = 3;
    localparam int c_flag_w     = 4;

endpackage
`default_nettype wire

// File: rtl/arith_seq_mul.sv
`default_nettype none
// ============================================================================
// Module   : arith_seq_mul
// Purpose  : Iterative unsigned shift-add multiplier, one partial product per
//            clock. The final iteration is combinational on o_prod while
//            o_done is high, so the product is available WIDTH-1 edges after
//            the start edge.
// Revision : 1.0 - initial release
// ============================================================================
module arith_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_prod
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    logic                 r_busy;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_prod;

    logic [2*WIDTH-1:0]   w_src;
    logic [WIDTH-1:0]     w_mcand;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_next;

    // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
    assign w_src   = i_start ? {{WIDTH{1'b0}}, i_b} : r_prod;
    assign w_mcand = i_start ? i_a : r_mcand;
    assign w_sum   = {1'b0, w_src[2*WIDTH-1:WIDTH]} + (w_src[0] ? {1'b0, w_mcand} : '0);
    assign w_next  = {w_sum, w_src[WIDTH-1:1]};

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_mcand <= '0;
            r_prod  <= '0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_cnt   <= CNT_W'(1);
            r_mcand <= i_a;
            r_prod  <= w_next;
        end else if (r_busy) begin
            r_prod <= w_next;
            if (r_cnt == c_last) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_done = r_busy && (r_cnt == c_last);
    assign o_prod = w_next;

endmodule
`default_nettype wire

// File: rtl/arith_seq_unit.sv
`default_nettype none
// ============================================================================
// Module   : arith_seq_unit
// Purpose  : Registered 8-operation arithmetic unit with valid/ready on both
//            sides. Define ARITH_SEQ_MUL_EN to build the iterative multiplier;
//            otherwise opcode 5 completes at once and flags o_err.
// Revision : 1.0 - initial release
// ============================================================================
module arith_seq_unit #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_d_a,
    input  logic [WIDTH-1:0] i_d_b,
    input  logic [2:0]       i_sel,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_out,
    output logic [WIDTH-1:0] o_hi,
    output logic             o_carry,
    output logic             o_ovf,
    output logic             o_zero,
    output logic             o_err
);
    import arith_seq_pkg::*;

    localparam int SH_W = $clog2(WIDTH);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [WIDTH-1:0]    r_out;
    logic [WIDTH-1:0]    r_hi;
    logic [c_flag_w-1:0] r_flags;

    logic                w_accept;
    logic                w_is_mul;
    logic [WIDTH:0]      w_add;
    logic [WIDTH:0]      w_sub;
    logic [SH_W-1:0]     w_sh;
    logic [WIDTH-1:0]    w_res;
    logic                w_carry;
    logic                w_ovf;
    logic                w_err;

    assign w_accept = i_valid && (r_state == ST_IDLE);
    assign w_add    = {1'b0, i_d_a} + {1'b0, i_d_b};
    assign w_sub    = {1'b0, i_d_a} - {1'b0, i_d_b};
    assign w_sh     = i_d_b[SH_W-1:0];

`ifdef ARITH_SEQ_MUL_EN
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_prod;

    assign w_is_mul = (i_sel == OP_MUL);

    arith_seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_start (w_accept && w_is_mul),
        .i_a     (i_d_a),
        .i_b     (i_d_b),
        .o_done  (w_mul_done),
        .o_prod  (w_prod)
    );
`else
    assign w_is_mul = 1'b0;
`endif

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        case (i_sel)
            OP_ADD: begin
                w_res   = w_add[WIDTH-1:0];
                w_carry = w_add[WIDTH];
                w_ovf   = (i_d_a[WIDTH-1] == i_d_b[WIDTH-1]) && (w_add[WIDTH-1] != i_d_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res   = w_sub[WIDTH-1:0];
                w_carry = w_sub[WIDTH];
                w_ovf   = (i_d_a[WIDTH-1] != i_d_b[WIDTH-1]) && (w_sub[WIDTH-1] != i_d_a[WIDTH-1]);
            end
            OP_AND: w_res = i_d_a & i_d_b;
            OP_OR:  w_res = i_d_a | i_d_b;
            OP_XOR: w_res = i_d_a ^ i_d_b;
`ifdef ARITH_SEQ_MUL_EN
            OP_MUL: w_err = 1'b0;
`else
            OP_MUL: w_err = 1'b1;
`endif
            OP_SHL: w_res = i_d_a << w_sh;
            OP_SHR: w_res = i_d_a >> w_sh;
            default: w_res = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_valid) w_state_nxt = w_is_mul ? ST_MUL : ST_DONE;
`ifdef ARITH_SEQ_MUL_EN
            ST_MUL:  if (w_mul_done) w_state_nxt = ST_DONE;
`endif
            ST_DONE: if (i_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Result registers only load on completion, so they hold through DONE.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_out   <= '0;
            r_hi    <= '0;
            r_flags <= '0;
        end else if (w_accept && !w_is_mul) begin
            r_out                 <= w_res;
            r_hi                  <= '0;
            r_flags[c_flag_carry] <= w_carry;
            r_flags[c_flag_ovf]   <= w_ovf;
            r_flags[c_flag_zero]  <= (w_res == '0);
            r_flags[c_flag_err]   <= w_err;
        end
`ifdef ARITH_SEQ_MUL_EN
        else if ((r_state == ST_MUL) && w_mul_done) begin
            r_out                 <= w_prod[WIDTH-1:0];
            r_hi                  <= w_prod[2*WIDTH-1:WIDTH];
            r_flags[c_flag_carry] <= 1'b0;
            r_flags[c_flag_ovf]   <= |w_prod[2*WIDTH-1:WIDTH];
            r_flags[c_flag_zero]  <= ~|w_prod;
            r_flags[c_flag_err]   <= 1'b0;
        end
`endif
    end

    assign o_ready = (r_state == ST_IDLE);
    assign o_valid = (r_state == ST_DONE);
    assign o_out   = r_out;
    assign o_hi    = r_hi;
    assign o_carry = r_flags[c_flag_carry];
    assign o_ovf   = r_flags[c_flag_ovf];
    assign o_zero  = r_flags[c_flag_zero];
    assign o_err   = r_flags[c_flag_err];

endmodule
`default_nettype wire

// File: tb/tb_arith_seq_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_arith_seq_unit
// Purpose  : Self-checking bench for arith_seq_unit (WIDTH=8), directed
//            vectors plus randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arith_seq_unit;

    localparam int W = 8;
`ifdef ARITH_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam int MUL_LAT = MUL_EN ? W : 1;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_ready = 1'b0;
    logic [2:0]   i_sel = '0;
    logic [W-1:0] i_d_a = '0;
    logic [W-1:0] i_d_b = '0;
    logic         o_ready, o_valid, o_carry, o_ovf, o_zero, o_err;
    logic [W-1:0] o_out, o_hi;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [W-1:0] out;
        logic [W-1:0] hi;
        logic         c;
        logic         v;
        logic         z;
        logic         e;
    } res_t;

    arith_seq_unit #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_d_a   (i_d_a),
        .i_d_b   (i_d_b),
        .i_sel   (i_sel),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_out   (o_out),
        .o_hi    (o_hi),
        .o_carry (o_carry),
        .o_ovf   (o_ovf),
        .o_zero  (o_zero),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;

    function automatic res_t got();
        return '{out: o_out, hi: o_hi, c: o_carry, v: o_ovf, z: o_zero, e: o_err};
    endfunction

    function automatic res_t mk(input logic [W-1:0] out, input logic [W-1:0] hi,
                                input logic c, input logic v, input logic z, input logic e);
        return '{out: out, hi: hi, c: c, v: v, z: z, e: e};
    endfunction

    // Plain-integer reference for every opcode.
    function automatic res_t ref_calc(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t   r;
        longint ua, ub, sa, sb, t, full;
        full = longint'(1) << W;
        ua = longint'(a);
        ub = longint'(b);
        sa = (ua >= full / 2) ? ua - full : ua;
        sb = (ub >= full / 2) ? ub - full : ub;
        r = '0;
        case (sel)
            3'd0: begin
                t = ua + ub; r.out = W'(t); r.c = (t >= full);
                r.v = ((sa + sb) > (full / 2 - 1)) || ((sa + sb) < -(full / 2));
            end
            3'd1: begin
                t = ua - ub; r.out = W'(t); r.c = (ua < ub);
                r.v = ((sa - sb) > (full / 2 - 1)) || ((sa - sb) < -(full / 2));
            end
            3'd2: r.out = a & b;
            3'd3: r.out = a | b;
            3'd4: r.out = a ^ b;
            3'd5: begin
                if (MUL_EN) begin
                    t = ua * ub; r.out = W'(t); r.hi = W'(t >> W);
                    r.v = (r.hi != 0); r.z = (t == 0);
                end else begin
                    r.z = 1'b1; r.e = 1'b1;
                end
            end
            3'd6: r.out = W'(ua << (ub % W));
            default: r.out = W'(ua >> (ub % W));
        endcase
        if (sel != 3'd5) r.z = (r.out == 0);
        return r;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Behavioural model: one job at a time, result visible lat-1 edges after accept.
    res_t m_exp  = '0;
    bit   m_done = 1'b0;
    int   m_wait = 0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_done <= 1'b0;
            m_wait <= 0;
        end else if (m_done) begin
            if (i_ready) m_done <= 1'b0;
        end else if (m_wait != 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) m_done <= 1'b1;
        end else if (i_valid) begin
            m_exp <= ref_calc(i_sel, i_d_a, i_d_b);
            if (i_sel == 3'd5 && MUL_LAT > 1) m_wait <= MUL_LAT - 1;
            else m_done <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            chk("handshake", {o_valid, o_ready}, {m_done, !m_done && m_wait == 0});
            if (m_done) chk("result", got(), m_exp);
        end
    end

    task automatic run_op(input string nm, input logic [2:0] sel, input logic [W-1:0] a,
                          input logic [W-1:0] b, input res_t exp, input int exp_lat);
        int guard;
        int lat;
        guard = 0;
        while (!o_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        i_valid = 1'b1; i_sel = sel; i_d_a = a; i_d_b = b; i_ready = 1'b0;
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk({nm, "_lat"}, lat, exp_lat);
        chk(nm, got(), exp);
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_outs", got(), 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        run_op("add_100_97", 3'd0, 8'd100, 8'd97, mk(8'hC5, 8'h00, 0, 1, 0, 0), 1);
        run_op("sub_2_1",    3'd1, 8'd2,   8'd1,  mk(8'h01, 8'h00, 0, 0, 0, 0), 1);
        run_op("sub_1_2",    3'd1, 8'd1,   8'd2,  mk(8'hFF, 8'h00, 1, 0, 0, 0), 1);
        run_op("mul_15_15",  3'd5, 8'd15,  8'd15,
               MUL_EN ? mk(8'hE1, 8'h00, 0, 0, 0, 0) : mk(8'h00, 8'h00, 0, 0, 1, 1), MUL_LAT);
        run_op("mul_100_97", 3'd5, 8'd100, 8'd97,
               MUL_EN ? mk(8'hE4, 8'h25, 0, 1, 0, 0) : mk(8'h00, 8'h00, 0, 0, 1, 1), MUL_LAT);
        run_op("xor_zero",   3'd4, 8'h0F,  8'h0F, mk(8'h00, 8'h00, 0, 0, 1, 0), 1);
        run_op("shl_81_1",   3'd6, 8'h81,  8'h01, mk(8'h02, 8'h00, 0, 0, 0, 0), 1);
        run_op("shr_80_7",   3'd7, 8'h80,  8'h07, mk(8'h01, 8'h00, 0, 0, 0, 0), 1);
        run_op("shl_bhigh",  3'd6, 8'h01,  8'h09, mk(8'h02, 8'h00, 0, 0, 0, 0), 1);
        run_op("add_wrap",   3'd0, 8'hFF,  8'h01, mk(8'h00, 8'h00, 1, 0, 1, 0), 1);
        run_op("sub_ovf",    3'd1, 8'h80,  8'h01, mk(8'h7F, 8'h00, 0, 1, 0, 0), 1);
        run_op("and",        3'd2, 8'hF0,  8'h3C, mk(8'h30, 8'h00, 0, 0, 0, 0), 1);
        run_op("or",         3'd3, 8'h0F,  8'h30, mk(8'h3F, 8'h00, 0, 0, 0, 0), 1);

        // Backpressure: result must hold and no new operand may be taken.
        i_valid = 1'b1; i_sel = 3'd0; i_d_a = 8'h10; i_d_b = 8'h20;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            i_valid = k[0]; i_sel = 3'd1; i_d_a = 8'($urandom); i_d_b = 8'($urandom);
            chk("bp_hold", got(), mk(8'h30, 8'h00, 0, 0, 0, 0));
            chk("bp_ready", o_ready, 0);
            @(posedge clk); #1;
        end
        i_valid = 1'b0; i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        run_op("after_bp", 3'd0, 8'd7, 8'd9, mk(8'h10, 8'h00, 0, 0, 0, 0), 1);

        // Reset three cycles into a multiply.
        i_valid = 1'b1; i_sel = 3'd5; i_d_a = 8'd100; i_d_b = 8'd97;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk("midrst_ready", o_ready, 1);
        chk("midrst_valid", o_valid, 0);
        chk("midrst_outs", got(), 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        run_op("add_2_1", 3'd0, 8'd2, 8'd1, mk(8'h03, 8'h00, 0, 0, 0, 0), 1);

        // Randomized traffic with corner-biased operands.
        for (int n = 0; n < 600; n++) begin
            logic [W-1:0] corners [4];
            corners[0] = 8'h00; corners[1] = 8'hFF; corners[2] = 8'h80; corners[3] = 8'h7F;
            i_valid = ($urandom_range(0, 9) < 6);
            i_ready = ($urandom_range(0, 3) != 0);
            i_sel   = 3'($urandom);
            i_d_a   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 8'($urandom);
            i_d_b   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 8'($urandom);
            @(posedge clk); #1;
        end
        i_valid = 1'b0; i_ready = 1'b1;
        repeat (W + 4) @(posedge clk);
        #1;
        chk("drain_idle", o_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
